// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 2;
  localparam int unsigned PC_STEP           = 4;

  // Default-width fetch result; fetch_unit builds its own entry type for other widths.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StBoot,
    StRun
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch results with synchronous flush; storage is reset so the
// head reads as zero straight out of reset.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned Depth   = FETCH_QUEUE_DEPTH,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Next pointer and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of a 1-cycle synchronous ROM. Owns the PC,
// tags the single in-flight read, queues results for decode and flushes on redirect.
// Optional macro FETCH_BYPASS_EN: a response arriving at an empty queue is shown
// on out_* in the same cycle and skips the queue if accepted.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ROM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic [ROM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]     imem_dout_i,
  input  logic                      redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     out_instr_o,
  output logic [ADDR_WIDTH-1:0]     out_pc_o,
  output logic [ADDR_WIDTH-1:0]     out_pc_plus4_o
);

  localparam int unsigned CntW = $clog2(FETCH_QUEUE_DEPTH + 1);
  localparam logic [CntW:0] OccLimit = (CntW + 1)'(FETCH_QUEUE_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_word_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  fetch_word_t     q_head;
  fetch_word_t     rsp;
  logic [CntW-1:0] q_count;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            pop;
  logic            issue;
  logic            rsp_bypass;
  logic [CntW:0]   occupancy;

  assign rsp     = '{instr: imem_dout_i, pc: inflight_pc_q};
  assign q_empty = (q_count == '0);

`ifdef FETCH_BYPASS_EN
  assign rsp_bypass  = q_empty && inflight_q;
  assign out_instr_o = rsp_bypass ? rsp.instr : q_head.instr;
  assign out_pc_o    = rsp_bypass ? rsp.pc    : q_head.pc;
`else
  assign rsp_bypass  = 1'b0;
  assign out_instr_o = q_head.instr;
  assign out_pc_o    = q_head.pc;
`endif

  assign out_pc_plus4_o = out_pc_o + ADDR_WIDTH'(PC_STEP);
  assign imem_addr_o    = fetch_pc_q[ROM_ADDR_WIDTH-1:0];

  // Handshake, push/pop and issue decisions; redirect suppresses all of them.
  always_comb begin
    out_valid_o = (!q_empty || rsp_bypass) && !redirect_valid_i;
    pop         = out_valid_o && out_ready_i;
    q_pop       = pop && !q_empty;
    // A bypassed response that decode takes this cycle never enters the queue.
    q_push      = inflight_q && !redirect_valid_i && !(rsp_bypass && pop);
    // pop implies count or inflight is non-zero, so this cannot underflow.
    occupancy   = (CntW + 1)'(q_count) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    issue       = (state_q == StRun) && !redirect_valid_i && (occupancy < OccLimit);
  end

  // FSM, PC and in-flight tag next state.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (redirect_valid_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
    end
    if (issue) inflight_pc_d = fetch_pc_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .entry_t(fetch_word_t),
    .Depth  (FETCH_QUEUE_DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_valid_i),
    .push_i     (q_push),
    .push_data_i(rsp),
    .pop_i      (q_pop),
    .head_o     (q_head),
    .count_o    (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a PC-wrap sequence
// on a second instance. Macro FETCH_BYPASS_EN selects the bypass-latency table.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, rv;
  logic [31:0] rpc;
  logic [9:0]  addr;
  logic [31:0] dout, instr, pc, pc4;
  logic        valid;

  logic        w_rdy, w_rv;
  logic [31:0] w_rpc;
  logic [9:0]  w_addr;
  logic [31:0] w_dout, w_instr, w_pc, w_pc4;
  logic        w_valid;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_addr_o     (addr),
    .imem_dout_i     (dout),
    .redirect_valid_i(rv),
    .redirect_pc_i   (rpc),
    .out_valid_o     (valid),
    .out_ready_i     (rdy),
    .out_instr_o     (instr),
    .out_pc_o        (pc),
    .out_pc_plus4_o  (pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_addr_o     (w_addr),
    .imem_dout_i     (w_dout),
    .redirect_valid_i(w_rv),
    .redirect_pc_i   (w_rpc),
    .out_valid_o     (w_valid),
    .out_ready_i     (w_rdy),
    .out_instr_o     (w_instr),
    .out_pc_o        (w_pc),
    .out_pc_plus4_o  (w_pc4)
  );

  // ROM models: word k holds 0x1000_0000 + k, one-cycle read latency.
  always @(posedge clk) begin
    dout   <= 32'h1000_0000 + {24'h0, addr[9:2]};
    w_dout <= 32'h1000_0000 + {24'h0, w_addr[9:2]};
  end

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return 32'h1000_0000 + {24'h0, p[9:2]};
  endfunction

  // kind: 0 = expect not valid, 1 = expect valid with epc, 2 = not valid and head zero
  typedef struct {
    logic        r;
    logic        rd;
    logic        v;
    logic [31:0] tp;
    int          kind;
    logic [31:0] epc;
    logic [9:0]  ea;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  task automatic add(input logic r, input logic rd, input logic v, input logic [31:0] tp,
                     input int kind, input logic [31:0] epc, input logic [9:0] ea);
    vecs[nvec] = '{r, rd, v, tp, kind, epc, ea};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rv = 1'b0; rpc = '0;
    w_rdy = 1'b1; w_rv = 1'b0; w_rpc = '0;

`ifdef FETCH_BYPASS_EN
    add(0, 1, 0, 0,     2, 0,     10'h000);  // BOOT
    add(0, 1, 0, 0,     0, 0,     10'h000);  // issue 0
    add(0, 0, 0, 0,     1, 32'h0, 10'h004);  // bypass 0, stalled
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 1, 0, 0,     1, 32'h0, 10'h008);  // release
    add(0, 1, 0, 0,     1, 32'h4, 10'h00C);
    add(0, 1, 0, 0,     1, 32'h8, 10'h010);
    add(0, 0, 0, 0,     1, 32'hC, 10'h014);  // fill queue
    add(0, 1, 1, 32'h40, 0, 0,    10'h014);  // redirect 0x40
    add(0, 1, 0, 0,     0, 0,     10'h040);
    add(0, 1, 0, 0,     1, 32'h40, 10'h044);
    add(0, 1, 1, 32'h43, 0, 0,    10'h048);  // redirect 0x43
    add(0, 1, 0, 0,     0, 0,     10'h040);
    add(0, 1, 1, 32'h80, 0, 0,    10'h044);
    add(0, 1, 1, 32'hC0, 0, 0,    10'h080);
    add(0, 1, 0, 0,     0, 0,     10'h0C0);
    add(0, 1, 0, 0,     1, 32'hC0, 10'h0C4);
    add(0, 1, 0, 0,     1, 32'hC4, 10'h0C8);
    add(0, 0, 0, 0,     1, 32'hC8, 10'h0CC);
    add(0, 0, 0, 0,     1, 32'hC8, 10'h0D0);
    add(1, 0, 0, 0,     1, 32'hC8, 10'h0D0);  // reset with queue full
    add(0, 1, 0, 0,     2, 0,     10'h000);
    add(0, 1, 0, 0,     0, 0,     10'h000);
    add(0, 1, 0, 0,     1, 32'h0, 10'h004);
`else
    add(0, 1, 0, 0,     2, 0,     10'h000);  // BOOT
    add(0, 1, 0, 0,     0, 0,     10'h000);  // issue 0
    add(0, 1, 0, 0,     0, 0,     10'h004);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);  // first valid, stalled
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 0, 0, 0,     1, 32'h0, 10'h008);
    add(0, 1, 0, 0,     1, 32'h0, 10'h008);  // release
    add(0, 1, 0, 0,     1, 32'h4, 10'h00C);
    add(0, 1, 0, 0,     1, 32'h8, 10'h010);
    add(0, 0, 0, 0,     1, 32'hC, 10'h014);  // fill queue
    add(0, 1, 1, 32'h40, 0, 0,    10'h014);  // redirect 0x40
    add(0, 1, 0, 0,     0, 0,     10'h040);
    add(0, 1, 0, 0,     0, 0,     10'h044);
    add(0, 1, 0, 0,     1, 32'h40, 10'h048);
    add(0, 1, 1, 32'h43, 0, 0,    10'h04C);  // redirect 0x43, drops in-flight 0x48
    add(0, 1, 0, 0,     0, 0,     10'h040);
    add(0, 1, 1, 32'h80, 0, 0,    10'h044);
    add(0, 1, 1, 32'hC0, 0, 0,    10'h080);
    add(0, 1, 0, 0,     0, 0,     10'h0C0);
    add(0, 1, 0, 0,     0, 0,     10'h0C4);
    add(0, 1, 0, 0,     1, 32'hC0, 10'h0C8);
    add(0, 1, 0, 0,     1, 32'hC4, 10'h0CC);
    add(0, 0, 0, 0,     1, 32'hC8, 10'h0D0);
    add(1, 0, 0, 0,     1, 32'hC8, 10'h0D0);  // reset with queue full
    add(0, 1, 0, 0,     2, 0,     10'h000);
    add(0, 1, 0, 0,     0, 0,     10'h000);
    add(0, 1, 0, 0,     0, 0,     10'h004);
    add(0, 1, 0, 0,     1, 32'h0, 10'h008);
`endif

    repeat (2) @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst = vecs[i].r; rdy = vecs[i].rd; rv = vecs[i].v; rpc = vecs[i].tp;
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].kind == 1});
      chk($sformatf("v%0d_addr", i), {22'b0, addr}, {22'b0, vecs[i].ea});
      if (vecs[i].kind == 1) begin
        chk($sformatf("v%0d_pc", i), pc, vecs[i].epc);
        chk($sformatf("v%0d_instr", i), instr, rom_word(vecs[i].epc));
        chk($sformatf("v%0d_pc4", i), pc4, vecs[i].epc + 32'd4);
      end else if (vecs[i].kind == 2) begin
        chk($sformatf("v%0d_pc_zero", i), pc, 32'h0);
        chk($sformatf("v%0d_instr_zero", i), instr, 32'h0);
      end
    end

    // PC wrap on the second instance.
    @(negedge clk);
    rst = 1'b1; rv = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrap_boot_valid", {31'b0, w_valid}, 32'h0);
    chk("wrap_boot_addr", {22'b0, w_addr}, 32'h3FC);
    for (int c = 1; c <= Lat + 2; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) chk("wrap_addr_c1", {22'b0, w_addr}, 32'h3FC);
      if (c == 2) chk("wrap_addr_c2", {22'b0, w_addr}, 32'h000);
      if (c >= Lat) begin
        chk($sformatf("wrap_c%0d_valid", c), {31'b0, w_valid}, 32'h1);
        chk($sformatf("wrap_c%0d_pc", c), w_pc, 32'hFFFF_FFFC + 32'(4 * (c - Lat)));
        chk($sformatf("wrap_c%0d_pc4", c), w_pc4, 32'(4 * (c - Lat)));
        chk($sformatf("wrap_c%0d_instr", c), w_instr,
            rom_word(32'hFFFF_FFFC + 32'(4 * (c - Lat))));
      end else begin
        chk($sformatf("wrap_c%0d_valid", c), {31'b0, w_valid}, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
